// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared memory port, one FSM that walks
// every instruction through FETCH/DECODE/EXEC and optionally MEM/WB.
// Unsupported instructions and misaligned word accesses park the core in HALT.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DBG_REG  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_inst,
    output logic [31:0] dbg_reg
);

    // Memory handshake: the core raises mem_req with mem_we/mem_addr/mem_wdata
    // and holds them stable; the access completes on the rising edge where
    // mem_req=1 and mem_ready=1 (mem_rdata is sampled on that same edge).
    // mem_ready is don't-care while mem_req=0.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] DBG_IDX = 5'(DBG_REG);

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] rf [0:31];

    // Instruction fields, always taken from the instruction register
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_ext;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm_ext = {{16{ir[15]}}, ir[15:0]};

    logic is_add, is_sub, is_slt, is_jr, is_addi, is_lw, is_sw;
    logic is_beq, is_bne, is_j, is_jal, is_alu, is_valid;

    // Classify the held instruction; anything not listed is invalid
    always_comb begin
        is_add   = (opcode == 6'h00) && (funct == 6'h20);
        is_sub   = (opcode == 6'h00) && (funct == 6'h22);
        is_slt   = (opcode == 6'h00) && (funct == 6'h2A);
        is_jr    = (opcode == 6'h00) && (funct == 6'h08);
        is_addi  = (opcode == 6'h08);
        is_lw    = (opcode == 6'h23);
        is_sw    = (opcode == 6'h2B);
        is_beq   = (opcode == 6'h04);
        is_bne   = (opcode == 6'h05);
        is_j     = (opcode == 6'h02);
        is_jal   = (opcode == 6'h03);
        is_alu   = is_add | is_sub | is_slt | is_addi;
        is_valid = is_alu | is_jr | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
    end

    logic [31:0] alu_res;

    // ALU: arithmetic wraps; loads/stores share the rs+imm adder with addi
    always_comb begin
        alu_res = a_reg + imm_ext;
        if (is_add) begin
            alu_res = a_reg + b_reg;
        end else if (is_sub) begin
            alu_res = a_reg - b_reg;
        end else if (is_slt) begin
            alu_res = {31'd0, ($signed(a_reg) < $signed(b_reg))};
        end
    end

    logic        branch_taken;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val;

    // Branch condition and write-back target selection
    always_comb begin
        branch_taken = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));
        wb_idx       = (opcode == 6'h00) ? rd : rt;
        wb_val       = is_lw ? mdr : alu_out;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    logic        req_c;
    logic        we_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;

    // Next-state logic and memory-port drive for the current state
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = 32'd0;
        wdata_c    = 32'd0;
        case (state)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = is_valid ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_next = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (is_alu) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = is_sw;
                addr_c  = alu_out;
                wdata_c = is_sw ? b_reg : 32'd0;
                if (mem_ready) begin
                    state_next = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // Datapath registers and register file; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_reg <= rf[rs];
                    b_reg <= rf[rt];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (branch_taken) begin
                        pc <= pc + {imm_ext[29:0], 2'b00};
                    end else if (is_j || is_jal) begin
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                    end else if (is_jr) begin
                        pc <= a_reg;
                    end
                    // pc already points past the jal, i.e. the return address
                    if (is_jal) begin
                        rf[31] <= pc;
                    end
                end
                S_MEM: begin
                    if (mem_ready && is_lw) begin
                        mdr <= mem_rdata;
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) begin
                        rf[wb_idx] <= wb_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset gates the port combinationally so an in-flight access drops at once
    assign mem_req   = req_c & rst_n;
    assign mem_we    = we_c & rst_n;
    assign mem_addr  = rst_n ? addr_c : 32'd0;
    assign mem_wdata = rst_n ? wdata_c : 32'd0;

    assign halted    = (state == S_HALT);
    assign dbg_pc    = pc;
    assign dbg_inst  = ir;
    assign dbg_reg   = rf[DBG_IDX];

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: an instruction-level model predicts every memory
// transaction (kind, address, data, completion edge) plus the halt point;
// a memory stub with scripted wait states serves the DUT and checks each
// completed access against the predicted queue.
module tb_multi_cycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic        mem_ready = 1'b0;
    logic        halted;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_inst;
    logic [31:0] dbg_reg;

    // Clock and DUT
    always #5 clk = ~clk;

    multi_cycle_cpu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .dbg_pc    (dbg_pc),
        .dbg_inst  (dbg_inst),
        .dbg_reg   (dbg_reg)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        logic [31:0] r16;
    } xact_t;

    logic [31:0] mem [0:255];
    logic [31:0] mm  [0:255];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_pc;
    xact_t       exp_q[$];
    int          wait_list[$];
    int          default_wait;
    int          acc_idx;
    int          wait_left;
    bit          busy;
    bit          chk_en;
    int          cyc;
    int          halt_cyc;
    int          pin_cyc;
    logic [31:0] pin_reg;
    logic [31:0] pin_pc;
    logic [31:0] pin_inst;
    int          obs_cyc[$];
    logic [31:0] obs_addr[$];
    logic        obs_we[$];
    logic [31:0] obs_wdata[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    function automatic int get_wait(input int i);
        return (i < wait_list.size()) ? wait_list[i] : default_wait;
    endfunction

    function automatic int oc(input int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] oa(input int i);
        return (i < obs_addr.size()) ? obs_addr[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
        mm[addr[9:2]]  = word;
    endtask

    // Program images and wait-state scripts
    task automatic load_prog(input int p);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'd0;
            mm[i]  = 32'd0;
        end
        wait_list.delete();
        default_wait = 0;
        pin_cyc = -1;
        case (p)
            1: begin
                put(32'h00, 32'h2011_0005);
                put(32'h04, 32'h2012_0013);
                put(32'h08, 32'h0232_8020);
                put(32'h0C, 32'hFC00_0000);
                pin_cyc  = 12;
                pin_reg  = 32'd24;
                pin_pc   = 32'd12;
                pin_inst = 32'h0232_8020;
            end
            2: begin
                put(32'h00, 32'h8C01_0080);
                put(32'h04, 32'hAC01_0040);
                put(32'h08, 32'h8C10_0040);
                put(32'h0C, 32'hFC00_0000);
                put(32'h80, 32'hDEAD_BEEF);
                wait_list = '{0, 0, 0, 2, 2, 2, 0};
            end
            3: begin
                put(32'h00, 32'h1000_0002);
                put(32'h0C, 32'h0C00_0008);
                put(32'h20, 32'h03E0_0008);
                put(32'h10, 32'h0800_000C);
                put(32'h30, 32'h03E0_8020);
                put(32'h34, 32'h2002_FFFD);
                put(32'h38, 32'h0040_802A);
                put(32'h3C, 32'h0002_8022);
                put(32'h40, 32'hFC00_0000);
            end
            4: begin
                put(32'h00, 32'h1400_0002);
                put(32'h04, 32'h2010_0009);
                put(32'h08, 32'h2000_0007);
                put(32'h0C, 32'h0000_8020);
                put(32'h10, 32'h8C05_0041);
            end
            5: begin
                put(32'h00, 32'h2010_0011);
                put(32'h04, 32'h2210_0001);
                put(32'h08, 32'hFC00_0000);
                default_wait = 1;
            end
            default: begin
                wait_list = '{0, 5};
                put(32'h00, 32'h2011_0005);
                put(32'h04, 32'h2012_0013);
            end
        endcase
    endtask

    // Instruction-level model: executes the image and records every bus access
    // with the clock edge it must complete on (edge 1 = first edge after reset).
    task automatic build_model();
        int          t;
        int          midx;
        int          wf;
        int          wd;
        logic [31:0] inst;
        logic [31:0] ext;
        logic [31:0] ea;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        xact_t       x;
        t = 1;
        midx = 0;
        m_pc = 32'd0;
        halt_cyc = -1;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        for (int n = 0; n < 200 && halt_cyc < 0; n++) begin
            wf = get_wait(midx);
            midx++;
            x.we = 1'b0; x.addr = m_pc; x.wdata = 32'd0; x.cyc = t + wf; x.r16 = m_reg[16];
            exp_q.push_back(x);
            inst = mm[m_pc[9:2]];
            m_pc = m_pc + 32'd4;
            rs = inst[25:21];
            rt = inst[20:16];
            rd = inst[15:11];
            ext = {{16{inst[15]}}, inst[15:0]};
            case (inst[31:26])
                6'h00: begin
                    case (inst[5:0])
                        6'h20: begin m_reg[rd] = m_reg[rs] + m_reg[rt]; t = t + wf + 4; end
                        6'h22: begin m_reg[rd] = m_reg[rs] - m_reg[rt]; t = t + wf + 4; end
                        6'h2A: begin
                            m_reg[rd] = ($signed(m_reg[rs]) < $signed(m_reg[rt])) ? 32'd1 : 32'd0;
                            t = t + wf + 4;
                        end
                        6'h08: begin m_pc = m_reg[rs]; t = t + wf + 3; end
                        default: halt_cyc = t + wf + 1;
                    endcase
                end
                6'h08: begin m_reg[rt] = m_reg[rs] + ext; t = t + wf + 4; end
                6'h23, 6'h2B: begin
                    ea = m_reg[rs] + ext;
                    if (ea[1:0] != 2'b00) begin
                        halt_cyc = t + wf + 2;
                    end else begin
                        wd = get_wait(midx);
                        midx++;
                        x.addr = ea; x.cyc = t + wf + 3 + wd; x.r16 = m_reg[16];
                        if (inst[31:26] == 6'h2B) begin
                            x.we = 1'b1; x.wdata = m_reg[rt];
                            mm[ea[9:2]] = m_reg[rt];
                            t = t + wf + 4 + wd;
                        end else begin
                            x.we = 1'b0; x.wdata = 32'd0;
                            m_reg[rt] = mm[ea[9:2]];
                            t = t + wf + 5 + wd;
                        end
                        exp_q.push_back(x);
                    end
                end
                6'h04: begin
                    if (m_reg[rs] == m_reg[rt]) m_pc = m_pc + (ext << 2);
                    t = t + wf + 3;
                end
                6'h05: begin
                    if (m_reg[rs] != m_reg[rt]) m_pc = m_pc + (ext << 2);
                    t = t + wf + 3;
                end
                6'h02: begin m_pc = {m_pc[31:28], inst[25:0], 2'b00}; t = t + wf + 3; end
                6'h03: begin
                    m_reg[31] = m_pc;
                    m_pc = {m_pc[31:28], inst[25:0], 2'b00};
                    t = t + wf + 3;
                end
                default: halt_cyc = t + wf + 1;
            endcase
            m_reg[0] = 32'd0;
        end
    endtask

    // Edge counter: edge 1 is the first rising edge with reset released
    always @(posedge clk) begin
        if (rst_n) cyc++;
    end

    // Memory stub plus scoreboard: responds on the falling edge so the access
    // completes on the following rising edge; also the per-cycle compare.
    always @(negedge clk) begin
        xact_t x;
        bit    exp_h;
        if (!rst_n) begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            busy = 1'b0;
        end else begin
            if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = get_wait(acc_idx);
                    acc_idx++;
                end
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    busy = 1'b0;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    obs_cyc.push_back(cyc + 1);
                    obs_addr.push_back(mem_addr);
                    obs_we.push_back(mem_we);
                    obs_wdata.push_back(mem_wdata);
                    if (chk_en) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_access: got addr %h we %b, expected none", mem_addr, mem_we);
                        end else begin
                            x = exp_q.pop_front();
                            check("xact_we", {31'd0, mem_we}, {31'd0, x.we});
                            check("xact_addr", mem_addr, x.addr);
                            check("xact_edge", 32'(cyc + 1), 32'(x.cyc));
                            check("xact_dbg_reg", dbg_reg, x.r16);
                            if (x.we) check("xact_wdata", mem_wdata, x.wdata);
                        end
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                    wait_left--;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
            if (chk_en) begin
                exp_h = (halt_cyc >= 0) && (cyc >= halt_cyc);
                check("halted", {31'd0, halted}, {31'd0, exp_h});
                if (exp_h) begin
                    check("halt_mem_req", {31'd0, mem_req}, 32'd0);
                    check("halt_dbg_pc", dbg_pc, m_pc);
                    check("halt_dbg_reg", dbg_reg, m_reg[16]);
                end
                if (cyc == pin_cyc) begin
                    check("pin_dbg_reg", dbg_reg, pin_reg);
                    check("pin_dbg_pc", dbg_pc, pin_pc);
                    check("pin_dbg_inst", dbg_inst, pin_inst);
                end
            end
        end
    end

    // Reset, build the model, release, and run until the halt plus a tail.
    // A nonzero abort_at instead pulls reset low at that edge count.
    task automatic run_program(input int p, input int abort_at);
        int guard;
        chk_en = 1'b0;
        rst_n = 1'b0;
        load_prog(p);
        exp_q.delete();
        obs_cyc.delete();
        obs_addr.delete();
        obs_we.delete();
        obs_wdata.delete();
        acc_idx = 0;
        cyc = 0;
        build_model();
        @(negedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_dbg_pc", dbg_pc, 32'd0);
        check("rst_dbg_inst", dbg_inst, 32'd0);
        check("rst_dbg_reg", dbg_reg, 32'd0);
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst_n = 1'b1;
        guard = 0;
        if (abort_at > 0) begin
            while (cyc < abort_at && guard < 3000) begin
                @(negedge clk);
                #1;
                guard++;
            end
            check("abort_pre_mem_req", {31'd0, mem_req}, 32'd1);
            check("abort_pre_dbg_pc", dbg_pc, 32'd4);
            check("abort_pre_mem_addr", mem_addr, 32'd4);
            chk_en = 1'b0;
            rst_n = 1'b0;
            #1;
            check("abort_mem_req", {31'd0, mem_req}, 32'd0);
            check("abort_mem_addr", mem_addr, 32'd0);
            check("abort_dbg_pc", dbg_pc, 32'd0);
            check("abort_dbg_inst", dbg_inst, 32'd0);
            check("abort_halted", {31'd0, halted}, 32'd0);
        end else begin
            while (!(halt_cyc >= 0 && cyc >= halt_cyc + 20) && guard < 3000) begin
                @(negedge clk);
                #1;
                guard++;
            end
            check("leftover_xacts", 32'(exp_q.size()), 32'd0);
            chk_en = 1'b0;
        end
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: program %0d got cyc %0d, expected halt by %0d", p, cyc, halt_cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Directed programs with hand-computed pins on top of the model checks
    initial begin
        // addi/addi/add: r16 = 24 after 12 edges, first fetch from address 0 on edge 1
        run_program(1, 0);
        check("p1_first_fetch_addr", oa(0), 32'd0);
        check("p1_first_fetch_edge", 32'(oc(0)), 32'd1);
        check("p1_halt_fetch_edge", 32'(oc(3)), 32'd13);

        // lw/sw through a slow memory: sw spans edges 6..11, lw spans 12..20
        run_program(2, 0);
        check("p2_sw_fetch_edge", 32'(oc(2)), 32'd6);
        check("p2_sw_store_edge", 32'(oc(3)), 32'd11);
        check("p2_sw_store_addr", oa(3), 32'h40);
        check("p2_sw_store_data", (obs_wdata.size() > 3) ? obs_wdata[3] : 32'd0, 32'hDEAD_BEEF);
        check("p2_lw_fetch_edge", 32'(oc(4)), 32'd14);
        check("p2_next_fetch_edge", 32'(oc(6)), 32'd21);
        check("p2_dbg_reg", dbg_reg, 32'hDEAD_BEEF);

        // beq taken, jal, jr, j, add/addi/slt/sub
        run_program(3, 0);
        check("p3_beq_target", oa(1), 32'd12);
        check("p3_beq_edge", 32'(oc(1)), 32'd4);
        check("p3_jal_target", oa(2), 32'h20);
        check("p3_jr_target", oa(3), 32'h10);
        check("p3_j_target", oa(4), 32'h30);
        check("p3_dbg_reg", dbg_reg, 32'd3);

        // bne not taken, writes to r0 ignored, misaligned lw halts
        run_program(4, 0);
        check("p4_bne_next", oa(1), 32'd4);
        check("p4_halted", {31'd0, halted}, 32'd1);
        check("p4_dbg_reg", dbg_reg, 32'd0);
        check("p4_dbg_pc", dbg_pc, 32'h14);

        // illegal opcode at PC 8
        run_program(5, 0);
        check("p5_halted", {31'd0, halted}, 32'd1);
        check("p5_dbg_pc", dbg_pc, 32'd12);
        check("p5_dbg_reg", dbg_reg, 32'h12);
        check("p5_mem_req", {31'd0, mem_req}, 32'd0);

        // reset during a stalled fetch, then a clean rerun from address 0
        run_program(6, 7);
        run_program(1, 0);
        check("p6_refetch_addr", oa(0), 32'd0);
        check("p6_refetch_edge", 32'(oc(0)), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
